// File: rtl/board_occupancy_scan_if.sv
// Handshake and result bus for the board occupancy scanner.
// master drives start and piece vectors; slave returns status and published maps.
interface board_occupancy_scan_if;
  localparam int unsigned NPIECE = 16;
  localparam int unsigned SQW    = 6;
  localparam int unsigned NSQ    = 64;
  localparam int unsigned CNTW   = 5;

  logic                    start;
  logic [NPIECE*SQW-1:0]   location_vectors_w;
  logic [NPIECE*SQW-1:0]   location_vectors_b;
  logic [NPIECE-1:0]       alive_vectors_w;
  logic [NPIECE-1:0]       alive_vectors_b;
  logic                    busy;
  logic                    done;
  logic [NSQ-1:0]          occupancy_w;
  logic [NSQ-1:0]          occupancy_b;
  logic [CNTW-1:0]         piece_count_w;
  logic [CNTW-1:0]         piece_count_b;
  logic                    collision;

  modport master (
    output start, location_vectors_w, location_vectors_b, alive_vectors_w, alive_vectors_b,
    input  busy, done, occupancy_w, occupancy_b, piece_count_w, piece_count_b, collision
  );

  modport slave (
    input  start, location_vectors_w, location_vectors_b, alive_vectors_w, alive_vectors_b,
    output busy, done, occupancy_w, occupancy_b, piece_count_w, piece_count_b, collision
  );
endinterface

// File: rtl/board_occupancy_scan.sv
// Serial 16-step scan building per-colour occupancy maps, piece counts and a collision flag
// from a snapshot of the piece vectors; results publish atomically at the end of the scan.
module board_occupancy_scan (
  input  logic                   clk,
  input  logic                   RST,
  board_occupancy_scan_if.slave  bus
);
  localparam int unsigned NPIECE = 16;
  localparam int unsigned SQW    = 6;
  localparam int unsigned NSQ    = 64;
  localparam int unsigned CNTW   = 5;
  localparam int unsigned KW     = 4;
  localparam int unsigned BASEW  = 7;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   load_c, merge_c, publish_c;

  logic [KW-1:0]          k_q;
  logic [NPIECE*SQW-1:0]  loc_w_q, loc_b_q;
  logic [NPIECE-1:0]      alive_w_q, alive_b_q;
  logic [NSQ-1:0]         work_w_q, work_b_q;
  logic [CNTW-1:0]        cnt_w_q, cnt_b_q;
  logic                   coll_q;

  logic [BASEW-1:0]       base_c;
  logic [SQW-1:0]         sq_w_c, sq_b_c;
  logic                   hit_w_c, hit_b_c, coll_c;
  logic [NSQ-1:0]         work_w_n_c, work_b_n_c;
  logic [CNTW-1:0]        cnt_w_n_c, cnt_b_n_c;
  logic                   coll_n_c;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_c    = 1'b0;
    merge_c   = 1'b0;
    publish_c = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        load_c  = 1'b1;
        state_d = SCAN;
      end
      SCAN: begin
        merge_c = 1'b1;
        if (k_q == KW'(NPIECE - 1)) begin
          publish_c = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Merge of white piece k and black piece k against the working maps built so far.
  always_comb begin
    base_c     = BASEW'(k_q) * BASEW'(SQW);
    sq_w_c     = loc_w_q[base_c +: SQW];
    sq_b_c     = loc_b_q[base_c +: SQW];
    hit_w_c    = alive_w_q[k_q];
    hit_b_c    = alive_b_q[k_q];
    coll_c     = (hit_w_c && (work_w_q[sq_w_c] || work_b_q[sq_w_c]))
              || (hit_b_c && (work_w_q[sq_b_c] || work_b_q[sq_b_c]))
              || (hit_w_c && hit_b_c && (sq_w_c == sq_b_c));
    work_w_n_c = work_w_q | (hit_w_c ? (NSQ'(1) << sq_w_c) : '0);
    work_b_n_c = work_b_q | (hit_b_c ? (NSQ'(1) << sq_b_c) : '0);
    cnt_w_n_c  = cnt_w_q + CNTW'(hit_w_c);
    cnt_b_n_c  = cnt_b_q + CNTW'(hit_b_c);
    coll_n_c   = coll_q | coll_c;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      k_q       <= '0;
      loc_w_q   <= '0;
      loc_b_q   <= '0;
      alive_w_q <= '0;
      alive_b_q <= '0;
      work_w_q  <= '0;
      work_b_q  <= '0;
      cnt_w_q   <= '0;
      cnt_b_q   <= '0;
      coll_q    <= 1'b0;
    end else if (load_c) begin
      k_q       <= '0;
      loc_w_q   <= bus.location_vectors_w;
      loc_b_q   <= bus.location_vectors_b;
      alive_w_q <= bus.alive_vectors_w;
      alive_b_q <= bus.alive_vectors_b;
      work_w_q  <= '0;
      work_b_q  <= '0;
      cnt_w_q   <= '0;
      cnt_b_q   <= '0;
      coll_q    <= 1'b0;
    end else if (merge_c) begin
      k_q       <= k_q + KW'(1);
      work_w_q  <= work_w_n_c;
      work_b_q  <= work_b_n_c;
      cnt_w_q   <= cnt_w_n_c;
      cnt_b_q   <= cnt_b_n_c;
      coll_q    <= coll_n_c;
    end
  end

  // Published results include the final merge and change only at the end of a scan.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      bus.occupancy_w   <= '0;
      bus.occupancy_b   <= '0;
      bus.piece_count_w <= '0;
      bus.piece_count_b <= '0;
      bus.collision     <= 1'b0;
    end else if (publish_c) begin
      bus.occupancy_w   <= work_w_n_c;
      bus.occupancy_b   <= work_b_n_c;
      bus.piece_count_w <= cnt_w_n_c;
      bus.piece_count_b <= cnt_b_n_c;
      bus.collision     <= coll_n_c;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.busy <= (state_d == SCAN);
      bus.done <= (state_d == DONE);
    end
  end
endmodule

// File: tb/tb_board_occupancy_scan.sv
// Scoreboard bench for board_occupancy_scan: expected scan results are queued at the
// accepting edge and compared, including done latency, whenever done pulses.
module tb_board_occupancy_scan;
  typedef struct {
    logic [63:0] ow;
    logic [63:0] ob;
    logic [4:0]  cw;
    logic [4:0]  cb;
    logic        coll;
    int          due;
  } exp_t;

  logic clk;
  logic RST;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  board_occupancy_scan_if bus ();

  board_occupancy_scan dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d cycles required=finish", cyc);
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h required=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Independent model: count pieces per square, collision is any square holding two or more.
  function automatic exp_t model(input logic [95:0] lw, input logic [95:0] lb,
                                 input logic [15:0] aw, input logic [15:0] ab);
    exp_t e;
    int   cnt [64];
    int   sq;
    e.ow = '0; e.ob = '0; e.cw = '0; e.cb = '0; e.coll = 1'b0; e.due = 0;
    for (int s = 0; s < 64; s++) cnt[s] = 0;
    for (int i = 0; i < 16; i++) begin
      if (aw[i]) begin
        sq = int'(lw[6*i +: 6]);
        e.ow[sq] = 1'b1; e.cw = e.cw + 5'd1; cnt[sq]++;
      end
      if (ab[i]) begin
        sq = int'(lb[6*i +: 6]);
        e.ob[sq] = 1'b1; e.cb = e.cb + 5'd1; cnt[sq]++;
      end
    end
    for (int s = 0; s < 64; s++) if (cnt[s] > 1) e.coll = 1'b1;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(bus.done), 64'(0));
      end else begin
        e = sb.pop_front();
        check("done_latency", 64'(cyc), 64'(e.due));
        check("occupancy_w", bus.occupancy_w, e.ow);
        check("occupancy_b", bus.occupancy_b, e.ob);
        check("piece_count_w", 64'(bus.piece_count_w), 64'(e.cw));
        check("piece_count_b", 64'(bus.piece_count_b), 64'(e.cb));
        check("collision", 64'(bus.collision), 64'(e.coll));
        check("busy_in_done", 64'(bus.busy), 64'(0));
      end
    end
  end

  task automatic set_vec(input logic [95:0] lw, input logic [95:0] lb,
                         input logic [15:0] aw, input logic [15:0] ab);
    bus.location_vectors_w = lw;
    bus.location_vectors_b = lb;
    bus.alive_vectors_w    = aw;
    bus.alive_vectors_b    = ab;
  endtask

  task automatic push_expected();
    exp_t e;
    e = model(bus.location_vectors_w, bus.location_vectors_b,
              bus.alive_vectors_w, bus.alive_vectors_b);
    e.due = cyc + 16;
    sb.push_back(e);
  endtask

  // Called just after an edge with the DUT idle; pulses start for one edge.
  task automatic run_scan();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    push_expected();
    check("busy_after_start", 64'(bus.busy), 64'(1));
    bus.start = 1'b0;
  endtask

  task automatic wait_sb();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (sb.size() != 0) begin
      check("scan_timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_occ_w"}, bus.occupancy_w, 64'(0));
    check({tag, "_occ_b"}, bus.occupancy_b, 64'(0));
    check({tag, "_cnt_w"}, 64'(bus.piece_count_w), 64'(0));
    check({tag, "_cnt_b"}, 64'(bus.piece_count_b), 64'(0));
    check({tag, "_coll"}, 64'(bus.collision), 64'(0));
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_done"}, 64'(bus.done), 64'(0));
  endtask

  logic [95:0] lw_a, lb_a, lw_c, lb_c;

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0;
    RST = 1'b0;
    bus.start = 1'b0;
    set_vec('0, '0, '0, '0);

    // Standard layout: white i on square i, black i on square 48+i.
    for (int i = 0; i < 16; i++) begin
      lw_a[6*i +: 6] = 6'(i);
      lb_a[6*i +: 6] = 6'(48 + i);
    end
    // Collision layout: white 0 and black 3 on square 10, others distinct.
    for (int i = 0; i < 16; i++) begin
      lw_c[6*i +: 6] = 6'(20 + i);
      lb_c[6*i +: 6] = 6'(40 + i);
    end
    lw_c[5:0]   = 6'd10;
    lb_c[23:18] = 6'd10;

    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    RST = 1'b1;
    @(posedge clk);
    #1;

    set_vec(lw_a, lb_a, 16'hFFFF, 16'hFFFF);
    run_scan();
    wait_sb();

    set_vec(lw_a, lb_a, 16'h0000, 16'h0001);
    run_scan();
    wait_sb();

    set_vec(lw_c, lb_c, 16'hFFFF, 16'hFFFF);
    run_scan();
    wait_sb();
    set_vec(lw_c, lb_c, 16'hFFFF, 16'hFFF7);
    run_scan();
    wait_sb();

    // Same-index white/black collision and same-colour collision.
    set_vec(lw_a, lb_a, 16'hFFFF, 16'hFFFF);
    bus.location_vectors_b[17:12] = 6'd2;
    run_scan();
    wait_sb();
    set_vec(lw_a, lb_a, 16'hFFFF, 16'h0000);
    bus.location_vectors_w[35:30] = 6'd1;
    run_scan();
    wait_sb();

    // Random boards; small square range forces frequent collisions.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        bus.location_vectors_w[6*i +: 6] = 6'($urandom_range(0, (r < 3) ? 63 : 20));
        bus.location_vectors_b[6*i +: 6] = 6'($urandom_range(0, (r < 3) ? 63 : 20));
      end
      bus.alive_vectors_w = 16'($urandom);
      bus.alive_vectors_b = 16'($urandom);
      run_scan();
      wait_sb();
    end

    // Inputs changed and start re-pulsed mid-scan: snapshot governs, no second scan.
    set_vec(lw_a, lb_a, 16'hA5A5, 16'h5A5A);
    run_scan();
    repeat (2) @(posedge clk);
    #1;
    set_vec(lw_c, lb_c, 16'hFFFF, 16'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_sb();
    repeat (25) @(posedge clk);
    #1;
    check("no_second_scan_busy", 64'(bus.busy), 64'(0));

    // Asynchronous reset mid-scan after a completed scan.
    check("prior_scan_nonzero", 64'(bus.occupancy_w != 64'(0)), 64'(1));
    set_vec(lw_c, lb_c, 16'hFFFF, 16'hFFFF);
    run_scan();
    repeat (7) @(posedge clk);
    #3;
    RST = 1'b0;
    #1;
    check_zero_outputs("midscan_rst");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_held_done", 64'(bus.done), 64'(0));
    @(negedge clk);
    RST = 1'b1;
    @(posedge clk);
    #1;
    set_vec(lw_a, lb_a, 16'hFFFF, 16'hFFFF);
    run_scan();
    wait_sb();

    // start held high: accepts every 18 edges, busy only for the 16 scan cycles.
    set_vec(lw_c, lb_c, 16'h0FF0, 16'hF00F);
    bus.start = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      #1;
      push_expected();
      if (s == 2) bus.start = 1'b0;
      for (int j = 0; j < 18; j++) begin
        check("held_start_busy", 64'(bus.busy), 64'(j < 16));
        if (j != 17) begin
          @(posedge clk);
          #1;
        end
      end
    end
    wait_sb();
    repeat (20) @(posedge clk);
    #1;
    check("held_start_idle", 64'(bus.busy), 64'(0));
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
